// File: rtl/router_fsm.sv
// router_fsm: packet-level controller for the 1x3 router (decode, load, full stall, parity).
module router_fsm #(
    parameter logic [1:0] INVALID_ADDR = 2'b11
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       pkt_valid,
    input  logic [1:0] data_in,
    input  logic       fifo_full,
    input  logic       fifo_empty_0,
    input  logic       fifo_empty_1,
    input  logic       fifo_empty_2,
    input  logic       soft_reset_0,
    input  logic       soft_reset_1,
    input  logic       soft_reset_2,
    input  logic       parity_done,
    input  logic       low_pkt_valid,
    output logic       detect_add,
    output logic       lfd_state,
    output logic       ld_state,
    output logic       laf_state,
    output logic       full_state,
    output logic       rst_int_reg,
    output logic       write_enb_reg,
    output logic       busy
);
    typedef enum logic [2:0] {DA, WTE, LFD, LD, FFS, LAF, LP, CPE} state_t;
    state_t     state_q, state_d;
    logic [1:0] addr_q, addr_d;
    logic       hdr_ok, hdr_empty, sel_empty, sel_soft_reset;
    function automatic logic pick(input logic [1:0] a, input logic v0, input logic v1, input logic v2);
        return a == 2'd0 ? v0 : a == 2'd1 ? v1 : a == 2'd2 ? v2 : 1'b0;
    endfunction
    assign hdr_ok         = pkt_valid && data_in != INVALID_ADDR;
    assign hdr_empty      = pick(data_in, fifo_empty_0, fifo_empty_1, fifo_empty_2);
    assign sel_empty      = pick(addr_q, fifo_empty_0, fifo_empty_1, fifo_empty_2);
    assign sel_soft_reset = pick(addr_q, soft_reset_0, soft_reset_1, soft_reset_2);
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= DA;
            addr_q  <= 2'd0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
        end
    end
    always_comb begin
        state_d = state_q;
        addr_d  = (state_q == DA && hdr_ok) ? data_in : addr_q;
        if (sel_soft_reset && state_q != DA) state_d = DA;
        else begin
            case (state_q)
                DA:      state_d = !hdr_ok ? DA : hdr_empty ? LFD : WTE;
                WTE:     state_d = sel_empty ? LFD : WTE;
                LFD:     state_d = LD;
                LD:      state_d = fifo_full ? FFS : !pkt_valid ? LP : LD;
                FFS:     state_d = fifo_full ? FFS : LAF;
                LAF:     state_d = parity_done ? DA : low_pkt_valid ? LP : LD;
                LP:      state_d = CPE;
                CPE:     state_d = fifo_full ? FFS : DA;
                default: state_d = DA;
            endcase
        end
    end
    // Moore outputs: decoded from the state register only
    assign detect_add    = state_q == DA;
    assign lfd_state     = state_q == LFD;
    assign ld_state      = state_q == LD;
    assign laf_state     = state_q == LAF;
    assign full_state    = state_q == FFS;
    assign rst_int_reg   = state_q == CPE;
    assign write_enb_reg = state_q == LD || state_q == LP || state_q == LAF;
    assign busy          = !(state_q == DA || state_q == LD);
endmodule
